// File: rtl/tensor_core_pkg.sv
// Shared types for the tensor core scheduler: matrix shape, element width and FSM states.
package tensor_core_pkg;

  localparam int MATRIX_DIM = 4;
  localparam int ELEM_W     = 8;

  typedef logic [ELEM_W-1:0] matrix_t [MATRIX_DIM][MATRIX_DIM];

  typedef enum logic [1:0] {
    TC_IDLE    = 2'd0,
    TC_LOAD    = 2'd1,
    TC_RUN     = 2'd2,
    TC_RESPOND = 2'd3
  } tc_sched_state_t;

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin pick: first asserted request at or after rr_ptr, wrapping modulo N.
module round_robin_arbiter #(
  parameter int N    = 2,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    request,
  input  logic [ID_W-1:0] rr_ptr,
  input  logic            enable,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id
);

  logic            found_s;
  logic            hit_s;
  logic [ID_W-1:0] idx_s;

  // Walk the requesters starting at the pointer and keep only the first hit.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found_s  = 1'b0;
    hit_s    = 1'b0;
    idx_s    = '0;
    for (int k = 0; k < N; k++) begin
      idx_s        = ID_W'((int'(rr_ptr) + k) % N);
      hit_s        = enable && !found_s && request[idx_s];
      grant[idx_s] = grant[idx_s] | hit_s;
      grant_id     = hit_s ? idx_s : grant_id;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/tensor_core_scheduler.sv
// Shares one small_tensor_core among several clients: round-robin accept, load, run with
// timeout, and return the captured result on a valid/ready port tagged with the client id.
module tensor_core_scheduler
  import tensor_core_pkg::*;
#(
  parameter int NUM_REQUESTERS = 2,
  parameter int TIMEOUT_CYCLES = 32,
  parameter int ID_W           = $clog2(NUM_REQUESTERS)
) (
  input  logic                      clock_in,
  input  logic                      reset_in,
  input  logic [NUM_REQUESTERS-1:0] request_valid,
  input  matrix_t                   request_input1 [NUM_REQUESTERS],
  input  matrix_t                   request_input2 [NUM_REQUESTERS],
  output logic [NUM_REQUESTERS-1:0] request_ready,
  output logic                      response_valid,
  input  logic                      response_ready,
  output logic [ID_W-1:0]           response_id,
  output matrix_t                   response_matrix,
  output logic                      response_timeout,
  output logic                      core_write_enable,
  output matrix_t                   core_input1,
  output matrix_t                   core_input2,
  input  matrix_t                   core_output,
  input  logic                      core_done
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  tc_sched_state_t           state_r;
  logic [ID_W-1:0]           rr_ptr_r;
  logic [CNT_W-1:0]          run_cnt_r;
  logic [ID_W-1:0]           id_r;
  logic                      resp_valid_r;
  logic                      resp_timeout_r;
  logic                      write_enable_r;
  matrix_t                   resp_matrix_r;
  matrix_t                   core_in1_r;
  matrix_t                   core_in2_r;

  logic                      arb_enable_s;
  logic [NUM_REQUESTERS-1:0] grant_s;
  logic [ID_W-1:0]           grant_id_s;
  logic                      accept_s;
  logic [ID_W-1:0]           rr_next_s;

  // Ready is only offered in IDLE, and never while reset is being applied.
  assign arb_enable_s = (state_r == TC_IDLE) && !reset_in;

  round_robin_arbiter #(
    .N    (NUM_REQUESTERS),
    .ID_W (ID_W)
  ) u_arbiter (
    .request  (request_valid),
    .rr_ptr   (rr_ptr_r),
    .enable   (arb_enable_s),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Pointer advances past the winner, wrapping at the last requester.
  always_comb begin
    accept_s  = |grant_s;
    rr_next_s = '0;
    if (grant_id_s == ID_W'(NUM_REQUESTERS - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_id_s + ID_W'(1);
    end
  end

  // Job sequencer: accept, single-cycle load pulse, run with timeout, hold response until taken.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_r        <= TC_IDLE;
      rr_ptr_r       <= '0;
      run_cnt_r      <= '0;
      id_r           <= '0;
      resp_valid_r   <= 1'b0;
      resp_timeout_r <= 1'b0;
      write_enable_r <= 1'b0;
      resp_matrix_r  <= '{default: 8'h00};
      core_in1_r     <= '{default: 8'h00};
      core_in2_r     <= '{default: 8'h00};
    end else begin
      case (state_r)
        TC_IDLE: begin
          if (accept_s) begin
            core_in1_r     <= request_input1[grant_id_s];
            core_in2_r     <= request_input2[grant_id_s];
            id_r           <= grant_id_s;
            rr_ptr_r       <= rr_next_s;
            write_enable_r <= 1'b1;
            state_r        <= TC_LOAD;
          end
        end
        TC_LOAD: begin
          write_enable_r <= 1'b0;
          run_cnt_r      <= '0;
          state_r        <= TC_RUN;
        end
        TC_RUN: begin
          run_cnt_r <= run_cnt_r + CNT_W'(1);
          // Done takes priority over the timeout in the same cycle.
          if (core_done) begin
            resp_matrix_r  <= core_output;
            resp_timeout_r <= 1'b0;
            resp_valid_r   <= 1'b1;
            state_r        <= TC_RESPOND;
          end else if (run_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            resp_matrix_r  <= '{default: 8'h00};
            resp_timeout_r <= 1'b1;
            resp_valid_r   <= 1'b1;
            state_r        <= TC_RESPOND;
          end
        end
        TC_RESPOND: begin
          if (response_ready) begin
            resp_valid_r <= 1'b0;
            state_r      <= TC_IDLE;
          end
        end
        default: begin
          state_r <= TC_IDLE;
        end
      endcase
    end
  end

  assign request_ready     = grant_s;
  assign response_valid    = resp_valid_r;
  assign response_id       = id_r;
  assign response_matrix   = resp_matrix_r;
  assign response_timeout  = resp_timeout_r;
  assign core_write_enable = write_enable_r;
  assign core_input1       = core_in1_r;
  assign core_input2       = core_in2_r;

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed/randomized bench for tensor_core_scheduler with a behavioural 16-step core model.
module tb_tensor_core_scheduler;
  import tensor_core_pkg::*;

  localparam int N  = 2;
  localparam int IW = $clog2(N);

  logic          clock_in = 1'b0;
  logic          reset_in;
  logic [N-1:0]  request_valid;
  logic [N-1:0]  request_ready;
  matrix_t       request_input1 [N];
  matrix_t       request_input2 [N];
  logic          response_valid;
  logic          response_ready;
  logic [IW-1:0] response_id;
  matrix_t       response_matrix;
  logic          response_timeout;
  logic          core_write_enable;
  matrix_t       core_input1;
  matrix_t       core_input2;
  matrix_t       core_output;
  logic          core_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int core_mode = 0;  // 0 nominal core, 1 never done, 2 done only on its 32nd run cycle
  int exp_ptr = 0;
  int last_t0 = 0;
  int last_hs = 0;
  logic [127:0] last_resp;

  logic [5:0] core_cnt = 6'd0;
  logic       core_busy = 1'b0;
  logic [7:0] core_acc;

  always #5 clock_in = ~clock_in;

  tensor_core_scheduler #(
    .NUM_REQUESTERS (N),
    .TIMEOUT_CYCLES (32)
  ) dut (
    .clock_in          (clock_in),
    .reset_in          (reset_in),
    .request_valid     (request_valid),
    .request_input1    (request_input1),
    .request_input2    (request_input2),
    .request_ready     (request_ready),
    .response_valid    (response_valid),
    .response_ready    (response_ready),
    .response_id       (response_id),
    .response_matrix   (response_matrix),
    .response_timeout  (response_timeout),
    .core_write_enable (core_write_enable),
    .core_input1       (core_input1),
    .core_input2       (core_input2),
    .core_output       (core_output),
    .core_done         (core_done)
  );

  // Core stand-in: restarts on write enable, signals done 16 steps later, done stays until next load.
  always @(posedge clock_in) begin
    if (core_write_enable) begin
      core_busy <= 1'b1;
      core_cnt  <= 6'd0;
    end else if (core_busy && core_cnt != 6'd63) begin
      core_cnt <= core_cnt + 6'd1;
    end
  end

  assign core_done = core_busy && ((core_mode == 0 && core_cnt >= 6'd16) ||
                                   (core_mode == 2 && core_cnt == 6'd31));

  always_comb begin
    core_acc = 8'd0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        core_acc = 8'd0;
        for (int k = 0; k < 4; k++) core_acc = core_acc + 8'(core_input1[i][k] * core_input2[k][j]);
        core_output[i][j] = core_acc;
      end
    end
  end

  function automatic logic [127:0] flat(input matrix_t m);
    logic [127:0] f = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) f[(i*4+j)*8 +: 8] = m[i][j];
    return f;
  endfunction

  // Reference: plain integer matrix product reduced modulo 256.
  function automatic logic [127:0] ref_product(input matrix_t a, input matrix_t b);
    logic [127:0] f = '0;
    int s;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s = s + int'(a[i][k]) * int'(b[k][j]);
        f[(i*4+j)*8 +: 8] = 8'(s % 256);
      end
    return f;
  endfunction

  task automatic step();
    @(posedge clock_in);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_ops(input logic [IW-1:0] c);
    for (int r = 0; r < 4; r++)
      for (int q = 0; q < 4; q++) begin
        request_input1[c][r][q] = 8'($urandom);
        request_input2[c][r][q] = 8'($urandom);
      end
  endtask

  task automatic run_job(input logic [N-1:0] vmask, input int mode, input int hold,
                         input int exp_lat, input logic exp_to);
    logic          got;
    int            e;
    logic [IW-1:0] ei;
    logic [127:0]  exp_flat;
    logic [127:0]  held;
    core_mode      = mode;
    response_ready = (hold == 0);
    request_valid  = vmask;
    #1;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if ((request_ready & request_valid) != '0) begin
        got = 1'b1;
        break;
      end
      step();
    end
    check("accept_seen", got, 1);
    if (!got) return;
    e = exp_ptr;
    while (((int'(vmask) >> e) & 1) == 0) e = (e + 1) % N;
    ei = IW'(e);
    check("grant_onehot", request_ready, 128'(1) << e);
    exp_flat = exp_to ? '0 : ref_product(request_input1[ei], request_input2[ei]);
    last_t0  = cyc;
    exp_ptr  = (e + 1) % N;
    step();
    check("we_in_T1", core_write_enable, 1);
    check("ready_busy", request_ready, 0);
    rand_ops(ei);
    got = 1'b0;
    for (int k = 0; k < 80; k++) begin
      step();
      if (response_valid) begin
        got = 1'b1;
        break;
      end
      check("we_low_run", core_write_enable, 0);
    end
    check("resp_seen", got, 1);
    if (!got) return;
    check("latency", cyc - last_t0, exp_lat);
    check("resp_id", response_id, ei);
    check("resp_matrix", flat(response_matrix), exp_flat);
    check("resp_timeout", response_timeout, exp_to);
    last_resp = flat(response_matrix);
    held = last_resp;
    for (int h = 0; h < hold; h++) begin
      step();
      check("bp_valid", response_valid, 1);
      check("bp_matrix", flat(response_matrix), held);
      check("bp_id", response_id, ei);
      check("bp_no_ready", request_ready, 0);
    end
    if (hold > 0) begin
      response_ready = 1'b1;
      #1;
    end
    last_hs = cyc;
    step();
    check("valid_drop", response_valid, 0);
  endtask

  initial begin
    logic [127:0] b_flat;
    int           prev_t0;
    int           hs;
    logic         seen;

    reset_in       = 1'b1;
    request_valid  = '0;
    response_ready = 1'b0;
    rand_ops(1'b0);
    rand_ops(1'b1);
    step();
    step();
    reset_in = 1'b0;
    check("rst_resp_valid", response_valid, 0);
    check("rst_resp_id", response_id, 0);
    check("rst_timeout", response_timeout, 0);
    check("rst_we", core_write_enable, 0);
    check("rst_ready", request_ready, 0);
    check("rst_core_in1", flat(core_input1), 0);
    check("rst_core_in2", flat(core_input2), 0);
    check("rst_resp_matrix", flat(response_matrix), 0);

    // Single job: identity times B returns B.
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        request_input1[0][i][j] = (i == j) ? 8'd1 : 8'd0;
        request_input2[0][i][j] = 8'(4 * i + j);
      end
    b_flat = flat(request_input2[0]);
    run_job(2'b01, 0, 0, 19, 1'b0);
    check("single_equals_B", last_resp, b_flat);

    // Fairness with both clients always valid, back-to-back.
    for (int j = 0; j < 4; j++) begin
      prev_t0 = last_t0;
      run_job(2'b11, 0, 0, 19, 1'b0);
      if (j > 0) check("back_to_back", last_t0 - prev_t0, 20);
    end

    // Backpressure for 10 cycles, then the next accept follows the handshake directly.
    run_job(2'b11, 0, 10, 19, 1'b0);
    hs = last_hs;
    run_job(2'b11, 0, 0, 19, 1'b0);
    check("bp_next_accept", last_t0, hs + 1);

    run_job(2'b10, 1, 0, 34, 1'b1);
    run_job(2'b01, 2, 0, 34, 1'b0);

    // Reset in the middle of RUN discards the job and restores the pointer.
    core_mode      = 0;
    response_ready = 1'b1;
    request_valid  = 2'b01;
    #1;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if ((request_ready & request_valid) != '0) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    check("mid_accept", seen, 1);
    for (int k = 0; k < 10; k++) step();
    reset_in      = 1'b1;
    request_valid = '0;
    step();
    reset_in = 1'b0;
    check("mid_resp_valid", response_valid, 0);
    check("mid_we", core_write_enable, 0);
    check("mid_timeout", response_timeout, 0);
    check("mid_id", response_id, 0);
    check("mid_ready", request_ready, 0);
    check("mid_core_in1", flat(core_input1), 0);
    check("mid_core_in2", flat(core_input2), 0);
    check("mid_resp_matrix", flat(response_matrix), 0);
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (response_valid) seen = 1'b1;
    end
    check("mid_no_response", seen, 0);
    exp_ptr = 0;
    run_job(2'b11, 0, 0, 19, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tensor_core_scheduler.md
# tensor_core_scheduler

Sequencer and arbiter in front of `small_tensor_core`. It shares the single core among `NUM_REQUESTERS` clients and grants them round-robin. For each job it latches the granted client's operands into the core, pulses the core's write-enable, waits for done with a timeout, captures the 4x4 result and returns it through a valid/ready response port tagged with the requester id.

## Interface
- `NUM_REQUESTERS`, default 2: number of client ports, minimum 2.
- `TIMEOUT_CYCLES`, default 32: maximum RUN cycles before a job is aborted.
- `ID_W`, default `$clog2(NUM_REQUESTERS)`: width of the response id.

Ports:
- `clock_in`  in  1  single clock; everything is on its posedge.
- `reset_in`  in  1  synchronous, active-high reset.
- `request_valid`  in  [NUM_REQUESTERS]  client i holds operands valid.
- `request_input1`, `request_input2`  in  [NUM_REQUESTERS][4][4] x 8  operand matrices A and B per client.
- `request_ready`  out  [NUM_REQUESTERS]  one-hot; operands are accepted in the cycle where valid and ready are both high.
- `response_valid`  out  1  result available.
- `response_ready`  in  1  consumer accepts the result.
- `response_id`  out  ID_W  index of the requester that owns the result.
- `response_matrix`  out  [4][4] x 8  captured core output.
- `response_timeout`  out  1  job aborted; `response_matrix` is all zero.
- `core_write_enable`  out  1  drives the core's `tensor_core_register_file_write_enable`.
- `core_input1`, `core_input2`  out  [4][4] x 8  registered operands to the core.
- `core_output`  in  [4][4] x 8  core result.
- `core_done`  in  1  core `is_done_with_calculation`.

## Operation
- FSM states are IDLE, LOAD, RUN and RESPOND.
- **IDLE**
  - The arbiter picks the first asserted `request_valid` at or after `rr_ptr`, wrapping modulo N.
  - It drives `request_ready` one-hot for that index only, combinationally, and only in IDLE.
  - On the handshake it latches that client's operands into `core_input1`/`core_input2`, stores the id, sets `rr_ptr` to (id+1) mod N, and moves to LOAD.
  - With no requests it holds and `rr_ptr` is unchanged.
- **LOAD**: `core_write_enable` is 1 for exactly this cycle. It clears `run_cnt` and moves to RUN.
- **RUN**
  - `core_write_enable` is 0 and `run_cnt` increments every cycle.
  - If `core_done` is 1: capture `core_output` into `response_matrix`, set timeout to 0, go to RESPOND.
  - Else if `run_cnt` equals TIMEOUT_CYCLES-1: zero `response_matrix`, set timeout to 1, go to RESPOND.
  - If done arrives in the same cycle as the timeout condition, done wins.
- **RESPOND**
  - `response_valid` is 1. `response_id`, `response_matrix` and `response_timeout` stay stable until the handshake.
  - When `response_ready` is 1, `response_valid` falls on the next edge and the FSM returns to IDLE.
- `core_input1`/`core_input2` stay stable from LOAD through RESPOND. They change only on an IDLE accept.
- Arithmetic is the core's, 8-bit truncated. The scheduler does not modify data.

## Timing
- Reset values: state IDLE, `rr_ptr` 0, `run_cnt` 0.
- All outputs reset to 0: `request_ready`, `response_valid`, `response_id`, `response_matrix`, `response_timeout`, `core_write_enable`, `core_input1`, `core_input2`.
- Latency, with a nominal 16-step core and the accept cycle as T0:
  - T1 is LOAD.
  - T2..T18 are RUN; `core_done` is first seen high in T18.
  - `response_valid` is high from T19.
- If `response_ready` is already high when `response_valid` rises, the handshake completes in T19, the FSM is in IDLE at T20 and can accept at T20. Back-to-back period is 20 cycles.
- A requester dropping `request_valid` while the FSM is outside IDLE has no effect. Operands are sampled only at the accept edge.
- Stale `core_done` = 1 left over from the previous job is never sampled, because RUN starts only after the LOAD edge clears it.
- `reset_in` mid-job, in any state:
  - Next cycle the FSM is in IDLE with all outputs at reset values.
  - Any pending response is discarded and `core_write_enable` is 0.

## Structure
- Package `tensor_core_pkg` holds:
  - `MATRIX_DIM` = 4 and `ELEM_W` = 8.
  - typedef `matrix_t` (unpacked [4][4] of logic [7:0]).
  - the FSM state enum `tc_sched_state_t`.
- Sub-module `round_robin_arbiter`, parameterized by N, with inputs `request`, `rr_ptr` and `enable` and outputs `grant` (one-hot) and `grant_id`. It is purely combinational. The pointer register lives in the scheduler.
- The scheduler instantiates no core. Top level wires it to `small_tensor_core`.

## Test plan
- **Single job.** Client 0 sends A = identity and B[i][j] = 4i+j with the real core attached. Required: accept at T0, `core_write_enable` high only in T1, `response_valid` at T19, `response_id` 0, `response_matrix` equal to B, timeout 0.
- **Fairness.** Both clients hold valid for 4 jobs. Grants alternate 0,1,0,1 and `request_ready` is never two-hot.
- **Backpressure.** Hold `response_ready` low for 10 cycles in RESPOND. Outputs stay stable and no new `request_ready` is issued. Release, and the next accept lands one cycle after the handshake.
- **Timeout.** Stub `core_done` to 0. `response_valid` appears after 32 RUN cycles with timeout 1 and `response_matrix` all zero.
- **Reset mid-job.** Assert `reset_in` for one cycle in RUN (T10). Next cycle all outputs are 0 and no response is produced. A new request is accepted normally afterwards with `rr_ptr` back at 0.
- **Boundary.** Drive `core_done` high in the same cycle `run_cnt` equals 31. Required: timeout 0 and `core_output` captured.
